// File: rtl/regfile_wb_arb_if.sv
// Bundles the write-back, long-latency, decode read-port and register-file
// write-port signals of regfile_wb_arb.
interface regfile_wb_arb_if;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        ll_valid;
    logic [4:0]  ll_waddr;
    logic [31:0] ll_wdata;
    logic        ll_ready;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic        pend1;
    logic        pend2;
    logic        stall_req;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;

    modport master (
        output wb_we, wb_waddr, wb_wdata, ll_valid, ll_waddr, ll_wdata, raddr1, raddr2,
        input  ll_ready, pend1, pend2, stall_req, we, waddr, wdata
    );

    modport slave (
        input  wb_we, wb_waddr, wb_wdata, ll_valid, ll_waddr, ll_wdata, raddr1, raddr2,
        output ll_ready, pend1, pend2, stall_req, we, waddr, wdata
    );
endinterface

// File: rtl/regfile_wb_arb.sv
// Register-file write-port arbiter: pipeline write-back vs. queued long-latency results.
// Optional macro WB_ARB_BYPASS_EN lets an ll result into an empty FIFO write the port directly.
module regfile_wb_arb #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic             clk,
    input  logic             rst,
    regfile_wb_arb_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [4:0]       addr_q [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [PW-1:0]    wptr_q, rptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic [SW-1:0]    starve_q, starve_d;
    logic             stall_q, stall_d;

    logic             empty, full, head_valid, ll_ready_w;
    logic             g_stall, g_wb, g_drain, g_byp, pop, push, push_acc;
    logic [DEPTH-1:0] match1, match2;

    assign empty      = (count_q == '0);
    assign full       = (count_q == CW'(DEPTH));
    assign head_valid = valid_q[rptr_q];
    assign ll_ready_w = rst && !full;
    assign push_acc   = bus.ll_valid && ll_ready_w;

    // Priority: starvation drain, then pipeline write-back, then idle-cycle drain.
    assign g_stall = rst && stall_q && !empty && head_valid;
    assign g_wb    = rst && !g_stall && bus.wb_we && (bus.wb_waddr != 5'd0);
    assign g_drain = rst && !g_stall && !g_wb && !empty;
    assign pop     = g_stall || g_drain;

`ifdef WB_ARB_BYPASS_EN
    assign g_byp = rst && empty && !g_wb && push_acc && (bus.ll_waddr != 5'd0);
`else
    assign g_byp = 1'b0;
`endif

    assign push = push_acc && (bus.ll_waddr != 5'd0) && !g_byp;

    // A fresh push lands on a free slot, so it overrides any squash aimed at that address.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        assign match1[gi]  = valid_q[gi] && (addr_q[gi] == bus.raddr1);
        assign match2[gi]  = valid_q[gi] && (addr_q[gi] == bus.raddr2);
        assign valid_d[gi] = (push && (wptr_q == PW'(gi))) ? 1'b1 :
                             (valid_q[gi]
                              && !(g_wb && (addr_q[gi] == bus.wb_waddr))
                              && !(pop && (rptr_q == PW'(gi))));
    end

    assign bus.ll_ready  = ll_ready_w;
    assign bus.pend1     = rst && (bus.raddr1 != 5'd0) && (|match1);
    assign bus.pend2     = rst && (bus.raddr2 != 5'd0) && (|match2);
    assign bus.stall_req = stall_q;

    always_comb begin
        bus.we    = 1'b0;
        bus.waddr = 5'd0;
        bus.wdata = 32'd0;
        if (pop && head_valid) begin
            bus.we    = 1'b1;
            bus.waddr = addr_q[rptr_q];
            bus.wdata = data_q[rptr_q];
        end else if (g_wb) begin
            bus.we    = 1'b1;
            bus.waddr = bus.wb_waddr;
            bus.wdata = bus.wb_wdata;
        end else if (g_byp) begin
            bus.we    = 1'b1;
            bus.waddr = bus.ll_waddr;
            bus.wdata = bus.ll_wdata;
        end
    end

    assign count_d = count_q + CW'(push) - CW'(pop);

    always_comb begin
        starve_d = starve_q;
        if (empty || pop)
            starve_d = '0;
        else if (starve_q != SW'(STARVE_MAX))
            starve_d = starve_q + SW'(1);
    end

    // Stall holds until no valid entry remains; squashed leftovers drain in idle cycles.
    always_comb begin
        stall_d = stall_q;
        if (valid_d == '0)
            stall_d = 1'b0;
        else if (starve_d == SW'(STARVE_MAX))
            stall_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q  <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            starve_q <= '0;
            stall_q  <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            stall_q  <= stall_d;
            if (push)
                wptr_q <= wptr_q + PW'(1);
            if (pop)
                rptr_q <= rptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wptr_q] <= bus.ll_waddr;
            data_q[wptr_q] <= bus.ll_wdata;
        end
    end
endmodule
